// File: rtl/mseq_pkg.sv
// Shared defaults, width helpers and the assembly state type for the
// M-sequence bit packer.
package mseq_pkg;

  localparam int MSEQ_IN_WIDTH  = 16;
  localparam int MSEQ_OUT_WIDTH = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } asm_state_e;

  function automatic int lanes_f(input int out_w, input int in_w);
    return out_w / in_w;
  endfunction

  // One FIFO entry holds {last, keep, data}
  function automatic int entry_width_f(input int out_w, input int in_w);
    return 1 + lanes_f(out_w, in_w) + out_w;
  endfunction

  function automatic bit widths_ok_f(input int out_w, input int in_w);
    return (in_w > 0) && (out_w >= in_w) && ((out_w % in_w) == 0);
  endfunction

endpackage

// File: rtl/mseq_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is only
// taken when a pop happens on the same edge.
module mseq_sync_fifo
  import mseq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         MSEQ_clk,
  input  logic                         MSEQ_rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge MSEQ_clk) begin
    if (!MSEQ_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge MSEQ_clk) begin
    if (MSEQ_rst_n && w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mseq_bit_packer.sv
// Packs M-sequence beats little-endian into wide words, queues them in a small
// FWFT FIFO and counts words dropped because the FIFO was full.
module mseq_bit_packer
  import mseq_pkg::*;
#(
  parameter  int IN_WIDTH       = MSEQ_IN_WIDTH,
  parameter  int OUT_WIDTH      = MSEQ_OUT_WIDTH,
  parameter  int FIFO_DEPTH     = 4,
  parameter  int DROP_CNT_WIDTH = 16,
  localparam int LANES          = lanes_f(OUT_WIDTH, IN_WIDTH),
  localparam int FILL_W         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      MSEQ_clk,
  input  logic                      MSEQ_rst_n,
  input  logic [IN_WIDTH-1:0]       MSEQ_din,
  input  logic                      MSEQ_din_vld,
  input  logic                      MSEQ_flush,
  output logic [OUT_WIDTH-1:0]      MSEQ_dout,
  output logic [LANES-1:0]          MSEQ_dout_keep,
  output logic                      MSEQ_dout_last,
  output logic                      MSEQ_dout_vld,
  input  logic                      MSEQ_dout_rdy,
  output logic [FILL_W-1:0]         MSEQ_fill_lvl,
  output logic                      MSEQ_ovf,
  output logic [DROP_CNT_WIDTH-1:0] MSEQ_drop_cnt
);

  localparam int IDX_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ENTRY_W = entry_width_f(OUT_WIDTH, IN_WIDTH);

  if (!widths_ok_f(OUT_WIDTH, IN_WIDTH)) begin : g_bad_widths
    $error("mseq_bit_packer: OUT_WIDTH must be a multiple of IN_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mseq_bit_packer: FIFO_DEPTH must be a power of 2, at least 2");
  end

  asm_state_e                r_state;
  asm_state_e                w_state_next;
  logic [IDX_W-1:0]          r_idx;
  logic [OUT_WIDTH-1:0]      r_data;
  logic [OUT_WIDTH-1:0]      w_data_next;
  logic [LANES-1:0]          r_keep;
  logic [LANES-1:0]          w_keep_next;
  logic                      w_full_close;
  logic                      w_flush_close;
  logic                      w_close;
  logic                      w_pop;
  logic                      w_drop;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [ENTRY_W-1:0]        w_wr_entry;
  logic [ENTRY_W-1:0]        w_rd_entry;
  logic                      r_ovf;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  assign w_full_close  = MSEQ_din_vld && (r_idx == IDX_W'(LANES - 1));
  assign w_flush_close = MSEQ_flush && (MSEQ_din_vld || (r_state == ST_FILL));
  assign w_close       = w_full_close || w_flush_close;

  // Word as it stands once this cycle's beat (if any) is merged in
  always_comb begin
    w_data_next = r_data;
    w_keep_next = r_keep;
    for (int l = 0; l < LANES; l++) begin
      if (MSEQ_din_vld && (r_idx == IDX_W'(l))) begin
        w_data_next[l*IN_WIDTH +: IN_WIDTH] = MSEQ_din;
        w_keep_next[l]                      = 1'b1;
      end
    end
  end

  always_ff @(posedge MSEQ_clk) begin
    if (!MSEQ_rst_n) r_state <= ST_IDLE;
    else             r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (MSEQ_din_vld && !w_close) w_state_next = ST_FILL;
      ST_FILL: if (w_close)                  w_state_next = ST_IDLE;
      default:                               w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge MSEQ_clk) begin
    if (!MSEQ_rst_n || w_close) begin
      r_idx  <= '0;
      r_data <= '0;
      r_keep <= '0;
    end else if (MSEQ_din_vld) begin
      r_idx  <= r_idx + IDX_W'(1);
      r_data <= w_data_next;
      r_keep <= w_keep_next;
    end
  end

  // Upstream cannot stall, so a close into a full, non-draining FIFO is lost
  assign w_pop      = !w_fifo_empty && MSEQ_dout_rdy;
  assign w_drop     = w_close && w_fifo_full && !w_pop;
  assign w_wr_entry = {MSEQ_flush, w_keep_next, w_data_next};

  mseq_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .MSEQ_clk   (MSEQ_clk),
    .MSEQ_rst_n (MSEQ_rst_n),
    .i_push     (w_close),
    .i_wdata    (w_wr_entry),
    .i_pop      (w_pop),
    .o_rdata    (w_rd_entry),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (MSEQ_fill_lvl)
  );

  always_ff @(posedge MSEQ_clk) begin
    if (!MSEQ_rst_n) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
    end
  end

  assign {MSEQ_dout_last, MSEQ_dout_keep, MSEQ_dout} = w_rd_entry;
  assign MSEQ_dout_vld = !w_fifo_empty;
  assign MSEQ_ovf      = r_ovf;
  assign MSEQ_drop_cnt = r_drop_cnt;

endmodule
